// File: rtl/deck_receiver_if.sv
// Load and deal signal bundle between the shuffler/controller side and the
// deck receiver. The receiver connects through the slave modport; the
// environment driving the loads and deal requests uses master.
interface deck_receiver_if;
  logic       load_flag;
  logic [5:0] card;
  logic       reload;
  logic       deal_req;
  logic       deal_valid;
  logic [5:0] deal_card;
  logic [3:0] deal_rank;
  logic [1:0] deal_suit;
  logic [3:0] deal_points;
  logic [5:0] cards_left;
  logic       deck_ready;
  logic       deck_low;
  logic       dup_err;
  logic       load_err;

  modport master (
    output load_flag, card, reload, deal_req,
    input  deal_valid, deal_card, deal_rank, deal_suit, deal_points,
           cards_left, deck_ready, deck_low, dup_err, load_err
  );

  modport slave (
    input  load_flag, card, reload, deal_req,
    output deal_valid, deal_card, deal_rank, deal_suit, deal_points,
           cards_left, deck_ready, deck_low, dup_err, load_err
  );
endinterface

// File: rtl/deck_receiver.sv
// Deck receiver: captures a 52-card stream from the shuffler (one card every
// second clock), checks it for out-of-range and duplicate cards, and deals
// the stored cards in arrival order with rank/suit/points decoded.
module deck_receiver #(
  parameter int unsigned DECK_SIZE  = 52,
  parameter int unsigned LOW_THRESH = 15
) (
  input logic            clk,
  input logic            rst,
  deck_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, EMPTY} state_t;

  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] LOW  = 6'(LOW_THRESH);

  state_t         state;
  logic           phase;
  logic           lf_d;
  logic           rise;
  logic           capture;
  logic [5:0]     wr_ptr;
  logic [5:0]     rd_ptr;
  logic [5:0]     cards_left;
  logic [DECK_SIZE-1:0] seen;
  logic [5:0]     deck [DECK_SIZE];

  logic           deal_valid;
  logic [5:0]     deal_card;
  logic [3:0]     deal_rank;
  logic [1:0]     deal_suit;
  logic [3:0]     deal_points;
  logic           dup_err;
  logic           load_err;

  logic [5:0]     head;
  logic [5:0]     head_rem;
  logic [1:0]     head_suit;
  logic [3:0]     head_rank;
  logic [3:0]     head_points;

  // lf_d resets high, so a flag already high out of reset is not a rise
  assign rise    = bus.load_flag && !lf_d;
  // a reload or a falling load_flag on a capture edge drops that card
  assign capture = (state == LOAD) && phase && bus.load_flag && !bus.reload;

  // rd_ptr reaches 52 once the deck is exhausted; keep the read in range
  assign head = (rd_ptr < FULL) ? deck[rd_ptr] : '0;

  // decode the card at the read pointer with a compare chain by 13
  always_comb begin
    head_suit = 2'd0;
    head_rem  = head;
    if (head >= 6'd39) begin
      head_suit = 2'd3;
      head_rem  = head - 6'd39;
    end else if (head >= 6'd26) begin
      head_suit = 2'd2;
      head_rem  = head - 6'd26;
    end else if (head >= 6'd13) begin
      head_suit = 2'd1;
      head_rem  = head - 6'd13;
    end
    head_rank = head_rem[3:0] + 4'd1;
    if (head_rank == 4'd1)
      head_points = 4'd11;
    else if (head_rank > 4'd10)
      head_points = 4'd10;
    else
      head_points = head_rank;
  end

  // card storage, written in arrival order on each capture edge
  always_ff @(posedge clk) begin
    if (capture)
      deck[wr_ptr] <= bus.card;
  end

  // load/deal state machine with stream checking and registered deal outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      lf_d        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cards_left  <= '0;
      seen        <= '0;
      deal_valid  <= 1'b0;
      deal_card   <= '0;
      deal_rank   <= '0;
      deal_suit   <= '0;
      deal_points <= '0;
      dup_err     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      lf_d       <= bus.load_flag;
      deal_valid <= 1'b0;
      if (bus.reload) begin
        state      <= IDLE;
        phase      <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cards_left <= '0;
        seen       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state  <= LOAD;
              phase  <= 1'b1;
              wr_ptr <= '0;
              rd_ptr <= '0;
              seen   <= '0;
            end
          end
          LOAD: begin
            if (!bus.load_flag) begin
              load_err   <= 1'b1;
              state      <= IDLE;
              phase      <= 1'b0;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              cards_left <= '0;
              seen       <= '0;
            end else begin
              phase <= !phase;
              if (phase) begin
                wr_ptr     <= wr_ptr + 6'd1;
                cards_left <= cards_left + 6'd1;
                if (bus.card >= FULL)
                  load_err <= 1'b1;
                else if (seen[bus.card])
                  dup_err <= 1'b1;
                else
                  seen[bus.card] <= 1'b1;
                if (wr_ptr == LAST)
                  state <= READY;
              end
            end
          end
          READY: begin
            if (bus.deal_req && (cards_left != '0)) begin
              deal_valid  <= 1'b1;
              deal_card   <= head;
              deal_rank   <= head_rank;
              deal_suit   <= head_suit;
              deal_points <= head_points;
              rd_ptr      <= rd_ptr + 6'd1;
              cards_left  <= cards_left - 6'd1;
              if (cards_left == 6'd1)
                state <= EMPTY;
            end
          end
          EMPTY: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.deal_valid  = deal_valid;
  assign bus.deal_card   = deal_card;
  assign bus.deal_rank   = deal_rank;
  assign bus.deal_suit   = deal_suit;
  assign bus.deal_points = deal_points;
  assign bus.cards_left  = cards_left;
  assign bus.deck_ready  = (state == READY);
  assign bus.deck_low    = (state == READY) && (cards_left <= LOW);
  assign bus.dup_err     = dup_err;
  assign bus.load_err    = load_err;

endmodule

// File: tb/tb_deck_receiver.sv
// Bench for deck_receiver: drives shuffler-timed loads and deal requests,
// and compares every output against a queue-based model of the deck.
module tb_deck_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  deck_receiver_if bus ();

  deck_receiver #(.DECK_SIZE(52), .LOW_THRESH(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: remaining cards in deal order, plus flags
  int q[$];
  bit mseen[52];
  bit mready = 1'b0;
  bit mdup   = 1'b0;
  bit mlerr  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".left"},  bus.cards_left, q.size());
    chk({tag, ".ready"}, bus.deck_ready, mready);
    chk({tag, ".low"},   bus.deck_low,   (mready && q.size() <= 15) ? 1 : 0);
    chk({tag, ".dup"},   bus.dup_err,    mdup);
    chk({tag, ".lerr"},  bus.load_err,   mlerr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"},  bus.deal_valid,  0);
    chk({tag, ".card"},   bus.deal_card,   0);
    chk({tag, ".rank"},   bus.deal_rank,   0);
    chk({tag, ".suit"},   bus.deal_suit,   0);
    chk({tag, ".points"}, bus.deal_points, 0);
    chk({tag, ".left"},   bus.cards_left,  0);
    chk({tag, ".ready"},  bus.deck_ready,  0);
    chk({tag, ".low"},    bus.deck_low,    0);
    chk({tag, ".dup"},    bus.dup_err,     0);
    chk({tag, ".lerr"},   bus.load_err,    0);
  endtask

  task automatic model_capture(input int c);
    q.push_back(c);
    if (c >= 52)
      mlerr = 1'b1;
    else if (mseen[c])
      mdup = 1'b1;
    else
      mseen[c] = 1'b1;
  endtask

  task automatic model_clear();
    q.delete();
    mready = 1'b0;
    foreach (mseen[i]) mseen[i] = 1'b0;
  endtask

  task automatic shuffle(output int v[52]);
    for (int i = 0; i < 52; i++) v[i] = i;
    for (int i = 51; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = v[i]; v[i] = v[j]; v[j] = t;
    end
  endtask

  task automatic lower_flag();
    bus.load_flag = 1'b0;
    tick();
  endtask

  // shuffler-timed stream; n_cap < 52 drops load_flag after n_cap captures
  task automatic load_stream(input int v[52], input int n_cap, input string tag);
    bus.load_flag = 1'b1;
    bus.card      = 6'(v[0]);
    tick();
    model_clear();
    for (int i = 0; i < n_cap; i++) begin
      bus.card = 6'(v[i]);
      tick();
      model_capture(v[i]);
      if (i == 51) mready = 1'b1;
      if (i >= 50) check_status($sformatf("%s.cap%0d", tag, i));
      else chk($sformatf("%s.left%0d", tag, i), bus.cards_left, i + 1);
      if (i < 51) begin
        bus.card = 6'($urandom_range(0, 63));
        tick();
      end
    end
    if (n_cap < 52) begin
      bus.load_flag = 1'b0;
      tick();
      mlerr = 1'b1;
      model_clear();
      check_status({tag, ".abort"});
    end
  endtask

  // hold deal_req for n consecutive cycles, then check the pulse ends and data holds
  task automatic deal_burst(input int n, input string tag);
    int last;
    bit exp_v;
    last = -1;
    bus.deal_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_v = mready && (q.size() > 0);
      tick();
      chk($sformatf("%s.valid%0d", tag, k), bus.deal_valid, exp_v);
      if (exp_v) begin
        int c, r, p;
        c = q.pop_front();
        r = c % 13 + 1;
        p = (r == 1) ? 11 : ((r > 10) ? 10 : r);
        chk($sformatf("%s.card%0d", tag, k),   bus.deal_card,   c);
        chk($sformatf("%s.rank%0d", tag, k),   bus.deal_rank,   r);
        chk($sformatf("%s.suit%0d", tag, k),   bus.deal_suit,   c / 13);
        chk($sformatf("%s.points%0d", tag, k), bus.deal_points, p);
        if (q.size() == 0) mready = 1'b0;
        last = c;
      end
      check_status($sformatf("%s.st%0d", tag, k));
    end
    bus.deal_req = 1'b0;
    tick();
    chk({tag, ".pulse_end"}, bus.deal_valid, 0);
    if (last >= 0) chk({tag, ".hold"}, bus.deal_card, last);
  endtask

  task automatic do_reload(input string tag);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    model_clear();
    check_status(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[52];

    bus.load_flag = 1'b1;
    bus.card      = '0;
    bus.reload    = 1'b0;
    bus.deal_req  = 1'b0;

    // reset with load_flag already high: outputs clear, no load starts
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.card = 6'($urandom_range(0, 51));
      tick();
    end
    check_status("no_load_after_reset");
    lower_flag();

    // full load 51..0, then decode and exhaust
    for (int i = 0; i < 52; i++) v[i] = 51 - i;
    load_stream(v, 52, "load_desc");
    deal_burst(1, "deal51");
    deal_burst(1, "deal50");
    deal_burst(1, "deal49");
    chk("deal49.rank_const", bus.deal_rank, 11);
    chk("deal49.points_const", bus.deal_points, 10);
    deal_burst(33, "deal_to16");
    chk("left16.low", bus.deck_low, 0);
    deal_burst(1, "deal_to15");
    chk("left15.low", bus.deck_low, 1);
    chk("left15.left", bus.cards_left, 15);
    deal_burst(15, "deal_to0");
    chk("empty.ready", bus.deck_ready, 0);
    deal_burst(1, "deal53");

    // reload with load_flag still high: no new load until it toggles
    do_reload("reload_high");
    for (int i = 0; i < 8; i++) begin
      bus.card = 6'($urandom_range(0, 51));
      tick();
    end
    check_status("reload_high.idle");
    lower_flag();

    // ascending deck: card 0 decodes to ace of suit 0
    for (int i = 0; i < 52; i++) v[i] = i;
    load_stream(v, 52, "load_asc");
    deal_burst(1, "deal0");
    chk("deal0.rank_const", bus.deal_rank, 1);
    chk("deal0.suit_const", bus.deal_suit, 0);
    chk("deal0.points_const", bus.deal_points, 11);

    // reload and deal_req in the same cycle: reload wins
    bus.reload   = 1'b1;
    bus.deal_req = 1'b1;
    tick();
    bus.reload   = 1'b0;
    bus.deal_req = 1'b0;
    model_clear();
    chk("reload_deal.valid", bus.deal_valid, 0);
    check_status("reload_deal");

    // reload on a capture edge drops that capture
    lower_flag();
    bus.load_flag = 1'b1;
    bus.card      = 6'd5;
    tick();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    tick();
    tick();
    check_status("reload_capture");
    lower_flag();

    // duplicate card 7
    shuffle(v);
    begin
      int p, d;
      p = 0;
      for (int i = 0; i < 52; i++) if (v[i] == 7) p = i;
      d = (p + 1 + $urandom_range(0, 50)) % 52;
      v[d] = 7;
    end
    load_stream(v, 52, "load_dup");
    chk("dup.flag", bus.dup_err, 1);
    chk("dup.no_lerr", bus.load_err, 0);
    do_reload("reload_after_dup");
    lower_flag();

    // out-of-range card 60
    shuffle(v);
    v[$urandom_range(0, 51)] = 60;
    load_stream(v, 52, "load_60");
    chk("oor.flag", bus.load_err, 1);
    do_reload("reload_after_60");
    lower_flag();

    // reset mid-load clears everything on the next edge
    shuffle(v);
    bus.load_flag = 1'b1;
    bus.card      = 6'(v[0]);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.card = 6'(v[i]);
      tick();
      tick();
    end
    rst = 1'b0;
    tick();
    check_all_zero("reset_mid_load");
    rst = 1'b1;
    mdup  = 1'b0;
    mlerr = 1'b0;
    model_clear();
    lower_flag();

    // load_flag falls after 10 captures
    shuffle(v);
    load_stream(v, 10, "load_abort");
    deal_burst(1, "abort_deal");
    lower_flag();

    // randomized rounds: shuffled decks, optional duplicate, random deal runs
    for (int r = 0; r < 3; r++) begin
      shuffle(v);
      if ($urandom_range(0, 1) == 1) begin
        int a, b;
        a = $urandom_range(0, 51);
        b = (a + 1 + $urandom_range(0, 50)) % 52;
        v[b] = v[a];
      end
      load_stream(v, 52, $sformatf("rnd%0d", r));
      for (int k = 0; k < 4; k++)
        deal_burst($urandom_range(1, 16), $sformatf("rnd%0d.d%0d", r, k));
      do_reload($sformatf("rnd%0d.reload", r));
      lower_flag();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
